my_logic16_arbiter: RTL and testbench

- Shares one 16-bit bitwise logic unit among N_REQ requesters. The unit performs NOT/AND/OR/XOR, and the NOT path is built from my_not_16.
- Round-robin grant, one operation in flight at a time, with a registered response and a valid/ready handshake on both sides.
- Sits between the n2t register-level test harnesses or CPU-side masters and the shared combinational 16-bit gate datapath.

---
 rtl/my_logic16_pkg.sv | 19 +
 rtl/my_not_16.sv | 11 +
 rtl/my_rr_picker.sv | 40 ++++
 rtl/my_logic16_arbiter.sv | 147 ++++++++++++++
 tb/tb_my_logic16_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/my_logic16_pkg.sv
// Shared types and constants for the 16-bit logic-unit arbiter.
package my_logic16_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        OP_NOT = 2'd0,
        OP_AND = 2'd1,
        OP_OR  = 2'd2,
        OP_XOR = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/my_not_16.sv
// 16-bit bitwise inverter: one NOT gate per bit.
module my_not_16 (
    input  logic [15:0] a,
    output logic [15:0] y
);

    for (genvar gi = 0; gi < 16; gi++) begin : g_not
        assign y[gi] = ~a[gi];
    end

endmodule

// File: rtl/my_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping from N_REQ-1 back to 0. Produces a one-hot grant and its index.
module my_rr_picker #(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   idx,
    output logic             any
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest valid request wins.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (sum >= (IDW + 1)'(N_REQ)) begin
                sum = sum - (IDW + 1)'(N_REQ);
            end
            cand = sum[IDW-1:0];
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
        assign grant[gi] = any && (idx == IDW'(gi));
    end

endmodule

// File: rtl/my_logic16_arbiter.sv
// Round-robin arbiter sharing one 16-bit NOT/AND/OR/XOR unit among N_REQ
// requesters; one operation in flight, registered response.
// Optional feature: define MY_LOGIC16_ARB_STATS_EN to add a saturating
// grant_count output.
module my_logic16_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 16,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_data
`ifdef MY_LOGIC16_ARB_STATS_EN
    ,
    output logic [15:0]            grant_count
`endif
);

    import my_logic16_pkg::*;

    state_t           state_reg;
    logic [IDW-1:0]   rr_ptr_reg;
    op_t              op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDW-1:0]   id_reg;
    logic             rsp_valid_reg;
    logic [IDW-1:0]   rsp_id_reg;
    logic [WIDTH-1:0] rsp_data_reg;

    logic [N_REQ-1:0] pick_grant;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             grant_fire;

    logic [1:0]       op_arr [N_REQ];
    logic [WIDTH-1:0] a_arr  [N_REQ];
    logic [WIDTH-1:0] b_arr  [N_REQ];

    logic [WIDTH-1:0] not_y;
    logic [WIDTH-1:0] alu_y;

    // Unpack the flat per-requester buses into indexable arrays.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign op_arr[gi] = req_op[2*gi +: 2];
        assign a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
        assign b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
    end

    my_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr_reg),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Grants are only offered in IDLE and never while reset is held.
    assign req_ready  = (state_reg == IDLE && !reset) ? pick_grant : '0;
    assign grant_fire = (state_reg == IDLE) && pick_any;

    my_not_16 u_not (
        .a (a_reg),
        .y (not_y)
    );

    // Shared logic unit operating on the latched operands.
    always_comb begin
        alu_y = not_y;
        case (op_reg)
            OP_NOT:  alu_y = not_y;
            OP_AND:  alu_y = a_reg & b_reg;
            OP_OR:   alu_y = a_reg | b_reg;
            OP_XOR:  alu_y = a_reg ^ b_reg;
            default: alu_y = not_y;
        endcase
    end

    // Control FSM: grant and latch in IDLE, compute in EXEC, hold in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            op_reg        <= OP_NOT;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        op_reg     <= op_t'(op_arr[pick_idx]);
                        a_reg      <= a_arr[pick_idx];
                        b_reg      <= b_arr[pick_idx];
                        id_reg     <= pick_idx;
                        rr_ptr_reg <= (pick_idx == IDW'(N_REQ - 1)) ? '0 : pick_idx + IDW'(1);
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_reg  <= alu_y;
                    rsp_id_reg    <= id_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;

`ifdef MY_LOGIC16_ARB_STATS_EN
    logic [15:0] grant_count_reg;

    // Saturating count of grants issued since reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count_reg <= '0;
        end else if (grant_fire && grant_count_reg != 16'hFFFF) begin
            grant_count_reg <= grant_count_reg + 16'd1;
        end
    end

    assign grant_count = grant_count_reg;
`endif

endmodule

// File: tb/tb_my_logic16_arbiter.sv
// Directed self-checking bench for my_logic16_arbiter (N_REQ=4).
module tb_my_logic16_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
`ifdef MY_LOGIC16_ARB_STATS_EN
    logic [15:0] grant_count;
`endif

    int pass_cnt;
    int total_cnt;

    my_logic16_arbiter #(.N_REQ(4), .WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef MY_LOGIC16_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        req_op[2*i +: 2] = op;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b want=%b", req_ready, 4'b0000);
        else pass_cnt++;
        total_cnt++;
        if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id got=%0d want=0", rsp_id);
        else pass_cnt++;
        total_cnt++;
        if (rsp_data !== 16'h0000) $display("FAIL reset_rsp_data got=%h want=0000", rsp_data);
        else pass_cnt++;
`ifdef MY_LOGIC16_ARB_STATS_EN
        total_cnt++;
        if (grant_count !== 16'd0) $display("FAIL reset_grant_count got=%0d want=0", grant_count);
        else pass_cnt++;
`endif
        reset = 1'b0;
        @(negedge clk);
        #1;
        total_cnt++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0)
            $display("FAIL idle_no_req got ready=%b valid=%b want ready=0000 valid=0", req_ready, rsp_valid);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_not();
        // Grant cycle T: req0 only.
        set_req(0, 2'd0, 16'b1111100011111100, 16'h1234);
        req_valid = 4'b0001;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL not_grant got=%b want=0001", req_ready);
        else pass_cnt++;
        // T+1: change operands, they must not matter.
        @(negedge clk);
        req_valid = 4'b0000;
        set_req(0, 2'd1, 16'h0000, 16'h0000);
        #1;
        total_cnt++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0)
            $display("FAIL not_exec got ready=%b valid=%b want ready=0000 valid=0", req_ready, rsp_valid);
        else pass_cnt++;
        // T+2: response visible.
        @(negedge clk);
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'b0000011100000011)
            $display("FAIL not_rsp got valid=%b id=%0d data=%h want valid=1 id=0 data=0703", rsp_valid, rsp_id, rsp_data);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (rsp_valid !== 1'b0) $display("FAIL not_rsp_drop got=%b want=0", rsp_valid);
        else pass_cnt++;
        $display("test_not done");
    endtask

    task automatic test_logic_ops();
        logic [1:0]  ops [3];
        logic [15:0] exps [3];
        ops[0] = 2'd1; exps[0] = 16'hF000;
        ops[1] = 2'd3; exps[1] = 16'h0FF0;
        ops[2] = 2'd2; exps[2] = 16'hFFF0;
        for (int t = 0; t < 3; t++) begin
            set_req(1, ops[t], 16'hF0F0, 16'hFF00);
            req_valid = 4'b0010;
            #1;
            total_cnt++;
            if (req_ready !== 4'b0010) $display("FAIL op%0d_grant got=%b want=0010", ops[t], req_ready);
            else pass_cnt++;
            @(negedge clk);
            req_valid = 4'b0000;
            @(negedge clk);
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== exps[t])
                $display("FAIL op%0d_rsp got valid=%b id=%0d data=%h want valid=1 id=1 data=%h",
                         ops[t], rsp_valid, rsp_id, rsp_data, exps[t]);
            else pass_cnt++;
            @(negedge clk);
            $display("op %0d result %h", ops[t], rsp_data);
        end
    endtask

    task automatic test_backpressure();
        // rr_ptr now 2; all requesters valid, req2 must win.
        for (int i = 0; i < 4; i++) set_req(i, 2'd0, 16'h0000, 16'h0000);
        set_req(2, 2'd3, 16'h1234, 16'h00FF);
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0100) $display("FAIL bp_grant got=%b want=0100", req_ready);
        else pass_cnt++;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h12CB || rsp_id !== 2'd2 || req_ready !== 4'b0000)
                $display("FAIL bp_hold%0d got valid=%b data=%h id=%0d ready=%b want valid=1 data=12cb id=2 ready=0000",
                         c, rsp_valid, rsp_data, rsp_id, req_ready);
            else pass_cnt++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b1000 || rsp_data !== 16'h12CB)
            $display("FAIL bp_release got valid=%b ready=%b data=%h want valid=0 ready=1000 data=12cb",
                     rsp_valid, req_ready, rsp_data);
        else pass_cnt++;
        req_valid = 4'b0000;
        @(negedge clk);
        $display("test_backpressure done");
    endtask

    task automatic test_round_robin();
        int exp_id;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 2'd1, 16'hFFFF, 16'(i + 1));
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            exp_id = g % 4;
            #1;
            total_cnt++;
            if (req_ready !== 4'(1 << exp_id)) $display("FAIL rr_grant%0d got=%b want=%b", g, req_ready, 4'(1 << exp_id));
            else pass_cnt++;
            @(negedge clk);
            @(negedge clk);
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_data !== 16'(exp_id + 1))
                $display("FAIL rr_rsp%0d got valid=%b id=%0d data=%h want valid=1 id=%0d data=%h",
                         g, rsp_valid, rsp_id, rsp_data, exp_id, 16'(exp_id + 1));
            else pass_cnt++;
            $display("rr grant %0d -> id %0d", g, rsp_id);
            if (g == 4) req_valid = 4'b0000;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        // rr_ptr is 1; only req3 valid, so req3 is granted.
        set_req(3, 2'd2, 16'hAAAA, 16'h5555);
        set_req(0, 2'd0, 16'h00FF, 16'h0000);
        req_valid = 4'b1000;
        #1;
        total_cnt++;
        if (req_ready !== 4'b1000) $display("FAIL rst_mid_grant got=%b want=1000", req_ready);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        req_valid = 4'b1001;
        @(negedge clk);
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || rsp_id !== 2'd0 || req_ready !== 4'b0000)
            $display("FAIL rst_mid_clear got valid=%b data=%h id=%0d ready=%b want valid=0 data=0000 id=0 ready=0000",
                     rsp_valid, rsp_data, rsp_id, req_ready);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL rst_mid_regrant got=%b want=0001", req_ready);
        else pass_cnt++;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'hFF00)
            $display("FAIL rst_mid_rsp got valid=%b id=%0d data=%h want valid=1 id=0 data=ff00", rsp_valid, rsp_id, rsp_data);
        else pass_cnt++;
        @(negedge clk);
        $display("test_reset_mid done");
    endtask

`ifdef MY_LOGIC16_ARB_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        repeat (9) @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if (grant_count !== 16'd3) $display("FAIL stats_count got=%0d want=3", grant_count);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total_cnt++;
        if (grant_count !== 16'd0) $display("FAIL stats_reset got=%0d want=0", grant_count);
        else pass_cnt++;
        $display("test_stats done");
    endtask
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_not();
        test_logic_ops();
        test_backpressure();
        test_round_robin();
        test_reset_mid();
`ifdef MY_LOGIC16_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
